// File: rtl/tt_nibble_cmd_driver.sv
// Host-side initiator for a nibble-command user module: generates its clock and
// reset, holds each command for a fixed number of user clocks, and returns io_out.
module tt_nibble_cmd_driver #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_fn,
    input  logic [3:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [7:0] dut_io_in,
    input  logic [7:0] dut_io_out
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ARM,
        S_RST_HOLD,
        S_READY,
        S_DRV_ARM,
        S_DRV_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            uclk_q, uclk_d;
    logic [7:1]      io_q, io_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      fn_q, fn_d;
    logic [3:0]      data_q, data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            wrap, rise_ev, fall_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            uclk_q      <= 1'b0;
            io_q        <= '0;
            cnt_q       <= '0;
            fn_q        <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            uclk_q      <= uclk_d;
            io_q        <= io_d;
            cnt_q       <= cnt_d;
            fn_q        <= fn_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        wrap    = (div_q == DW'(CLK_DIV - 1));
        rise_ev = wrap & ~uclk_q;
        fall_ev = wrap & uclk_q;
        div_d   = wrap ? '0 : div_q + 1'b1;
        uclk_d  = uclk_q ^ wrap;

        state_d     = state_q;
        io_d        = io_q;
        cnt_d       = cnt_q;
        fn_d        = fn_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        // Gating on rsp_valid_q delays ready by one cycle after a response.
        cmd_ready   = (state_q == S_READY) & ~start & ~rsp_valid_q;

        if (start) begin
            state_d = S_RST_ARM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RST_ARM: begin
                    if (fall_ev) begin
                        io_d    = 7'b000_0001;
                        cnt_d   = '0;
                        state_d = S_RST_HOLD;
                    end
                end
                S_RST_HOLD: begin
                    if (rise_ev && cnt_q != 16'(RESET_CYCLES)) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (fall_ev && cnt_q == 16'(RESET_CYCLES)) begin
                        io_d[1] = 1'b0;
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (cmd_valid && cmd_ready) begin
                        fn_d    = cmd_fn;
                        data_d  = cmd_data;
                        state_d = S_DRV_ARM;
                    end
                end
                S_DRV_ARM: begin
                    if (fall_ev) begin
                        io_d[3:2] = fn_q;
                        io_d[7:4] = data_q;
                        cnt_d     = '0;
                        state_d   = S_DRV_HOLD;
                    end
                end
                S_DRV_HOLD: begin
                    if (rise_ev && cnt_q != 16'(HOLD_CYCLES)) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (fall_ev && cnt_q == 16'(HOLD_CYCLES)) begin
                        rsp_data_d  = dut_io_out;
                        rsp_valid_d = 1'b1;
                        io_d[3:2]   = 2'b00;
                        state_d     = S_READY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign dut_io_in = {io_q, uclk_q};
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q == S_RST_ARM) || (state_q == S_RST_HOLD) ||
                       (state_q == S_DRV_ARM) || (state_q == S_DRV_HOLD);

endmodule

// File: tb/tb_tt_nibble_cmd_driver.sv
// Directed bench for tt_nibble_cmd_driver: expected responses are queued at
// handshake and checked by an independent monitor on rsp_valid.
module tb_tt_nibble_cmd_driver;

    localparam int unsigned CD = 2;
    localparam int unsigned RC = 1;
    localparam int unsigned HC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_fn = '0;
    logic [3:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic [7:0] dut_io_in;
    logic [7:0] dut_io_out;
    logic       stub_fixed = 1'b1;

    int tests = 0;
    int fails = 0;
    int rsp_seen = 0;
    logic [7:0] exp_q[$];

    tt_nibble_cmd_driver #(
        .CLK_DIV(CD),
        .RESET_CYCLES(RC),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_fn(cmd_fn),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .dut_io_in(dut_io_in),
        .dut_io_out(dut_io_out)
    );

    always #5 clk = ~clk;

    // User-module stub: fixed pattern, or inverted data with fn echoed.
    assign dut_io_out = stub_fixed ? 8'hA5 : {~dut_io_in[7:4], 2'b00, dut_io_in[3:2]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_data);
            end else begin
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] fn, input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_fn    = fn;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_fn(input logic [1:0] fn, input string name);
        int t = 0;
        while (dut_io_in[3:2] != fn && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(name, {30'd0, dut_io_in[3:2]}, {30'd0, fn});
    endtask

    logic [1:0] bb_fn[2]  = '{2'b10, 2'b11};
    logic [3:0] bb_dat[2] = '{4'hC, 4'h3};
    logic [7:0] bb_exp[2] = '{8'h32, 8'hC3};

    initial begin
        int k, hi, lo, lat, n, t, idx, runs, zrun, gap, base;
        logic prev0, hs;
        logic [1:0] cur, prevfn;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {dut_io_in, 7'd0, cmd_ready, 7'd0, rsp_valid, rsp_data, 7'd0, busy}, 32'd0);

        rst_n = 1'b1;
        k = 0;
        while (!dut_io_in[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("clk_first_rise", k, CD);
        hi = 0;
        while (dut_io_in[0] && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        lo = 0;
        while (!dut_io_in[0] && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        chk("clk_high", hi, CD);
        chk("clk_low", lo, CD);
        chk("idle_io", {24'd0, dut_io_in[7:1], 1'b0}, 32'd0);
        chk("idle_not_ready", {31'd0, cmd_ready}, 32'd0);

        // Reset sequence
        pulse_start();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        prev0 = dut_io_in[0];
        t = 0;
        while (!dut_io_in[1] && t < 40) begin
            prev0 = dut_io_in[0];
            @(negedge clk);
            t++;
        end
        chk("rst_rise_on_fall", {30'd0, prev0, dut_io_in[0]}, 32'd2);
        n = 0;
        while (dut_io_in[1] && n < 40) begin
            n++;
            prev0 = dut_io_in[0];
            @(negedge clk);
        end
        chk("rst_width", n, RC * 2 * CD);
        chk("rst_fall_on_fall", {30'd0, prev0, dut_io_in[0]}, 32'd2);
        wait_ready("ready_after_reset");

        // Single command, fixed stub
        exp_q.push_back(8'hA5);
        issue(2'b01, 4'h0);
        chk("ready_drop", {31'd0, cmd_ready}, 32'd0);
        lat = 0;
        while (dut_io_in[3:2] == 2'b00 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("fn_latency_ok", {31'd0, (lat >= 1 && lat <= int'(2 * CD))}, 32'd1);
        n = 0;
        while (dut_io_in[3:2] == 2'b01 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("fn_hold", n, HC * 2 * CD);
        chk("rsp_with_fn_clear", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);

        // Back-to-back with cmd_valid held
        stub_fixed = 1'b0;
        base = rsp_seen;
        idx = 0; runs = 0; zrun = 0; gap = -1; t = 0; hs = 1'b0;
        prevfn = dut_io_in[3:2];
        cmd_valid = 1'b1;
        cmd_fn = bb_fn[0];
        cmd_data = bb_dat[0];
        while ((rsp_seen - base) < 2 && t < 300) begin
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(bb_exp[idx]);
                hs = 1'b1;
            end
            @(negedge clk);
            t++;
            if (hs) begin
                hs = 1'b0;
                idx++;
                if (idx < 2) begin
                    cmd_fn = bb_fn[idx];
                    cmd_data = bb_dat[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            cur = dut_io_in[3:2];
            if (cur != 2'b00 && prevfn == 2'b00) begin
                runs++;
                if (runs > 1) gap = zrun;
            end
            if (cur == 2'b00) zrun++;
            else zrun = 0;
            prevfn = cur;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepted", idx, 2);
        chk("b2b_responses", rsp_seen - base, 2);
        chk("b2b_fn_runs", runs, 2);
        chk("b2b_gap_ok", {31'd0, gap >= int'(CD)}, 32'd1);

        // Abort mid-DRIVE
        wait_ready("ready_before_abort");
        base = rsp_seen;
        issue(2'b01, 4'h9);
        wait_fn(2'b01, "abort_fn_driven");
        repeat (3) @(negedge clk);
        pulse_start();
        prev0 = dut_io_in[0];
        t = 0;
        while (!dut_io_in[1] && t < 40) begin
            prev0 = dut_io_in[0];
            @(negedge clk);
            t++;
        end
        chk("abort_io_cleared", {24'd0, dut_io_in[7:1], 1'b0}, 32'h02);
        chk("abort_on_fall", {30'd0, prev0, dut_io_in[0]}, 32'd2);
        wait_ready("ready_after_abort");
        chk("abort_no_rsp", rsp_seen - base, 0);

        // Async reset mid-DRIVE
        issue(2'b11, 4'h5);
        wait_fn(2'b11, "ar_fn_driven");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {dut_io_in, 7'd0, cmd_ready, 7'd0, rsp_valid, rsp_data, 7'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("ar_idle", {23'd0, cmd_ready, dut_io_in[7:1], busy}, 32'd0);
        pulse_start();
        wait_ready("ready_after_ar");
        base = rsp_seen;
        exp_q.push_back(8'h92);
        issue(2'b10, 4'h6);
        t = 0;
        while (rsp_seen == base && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ar_cmd_rsp", rsp_seen - base, 1);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
